// File: rtl/mips_pkg.sv
// Shared encodings and defaults for the MIPS pipeline control blocks.
package mips_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MD_LATENCY_DEFAULT = 32;
    localparam int         CNT_W_DEFAULT      = 16;

    // True when an ID source operand is read and matches a nonzero EX destination.
    function automatic logic src_hits(input logic       uses,
                                      input logic [4:0] id_r,
                                      input logic [4:0] ex_r);
        return uses && (id_r == ex_r) && (ex_r != REG_ZERO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard/sequencing control: load-use and mult/div-busy stalls,
// taken-branch squash, and saturating stall/flush performance counters.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_RUN     | mult/div idle; only load-use can stall
//   ST_MD_BUSY | mult/div in flight; md_cnt counts down to 0, HI/LO and
//              | further mult/div users in ID are held
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_MulDiv,
    input  logic             ID_ReadsHiLo,
    input  logic [4:0]       EX_Rw,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

    md_state_e  state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       load_use, md_hazard, stall, md_issue;
    logic       stall_inc, flush_inc;

    assign load_use  = EX_MemRead && EX_RegWrite &&
                       (src_hits(ID_UsesRs, ID_Rs, EX_Rw) ||
                        src_hits(ID_UsesRt, ID_Rt, EX_Rw));
    assign md_hazard = (state_q == ST_MD_BUSY) && (ID_ReadsHiLo || ID_MulDiv);
    assign stall     = load_use || md_hazard;
    assign md_issue  = (state_q == ST_RUN) && ID_MulDiv && !stall && !EX_BranchTaken;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // A taken branch never cancels an in-flight mult/div: it is older than the branch.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (md_issue) begin
                    state_d  = ST_MD_BUSY;
                    md_cnt_d = MD_INIT;
                end
            end
            ST_MD_BUSY: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        MdBusy     = !Reset && (state_q == ST_MD_BUSY);
        if (Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (EX_BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    assign stall_inc = !Reset && !EX_BranchTaken && stall;
    assign flush_inc = !Reset && EX_BranchTaken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (CLK),
        .clr_i (Reset),
        .inc_i (stall_inc),
        .cnt_o (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (CLK),
        .clr_i (Reset),
        .inc_i (flush_inc),
        .cnt_o (FlushCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit (MD_LATENCY=4, CNT_W=16).
module tb_hazard_control_unit;

    localparam int CNT_W = 16;

    // Output vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MdBusy}
    localparam logic [4:0] E_NORM  = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00010;
    localparam logic [4:0] E_FLUSH = 5'b11110;
    localparam logic [4:0] E_RST   = 5'b00110;
    localparam logic [4:0] BUSY    = 5'b00001;

    typedef struct {
        string            nm;
        logic [4:0]       o;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic             clk = 1'b0;
    logic             Reset;
    logic [4:0]       ID_Rs, ID_Rt, EX_Rw;
    logic             ID_UsesRs, ID_UsesRt, ID_MulDiv, ID_ReadsHiLo;
    logic             EX_MemRead, EX_RegWrite, EX_BranchTaken;
    logic             PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MdBusy;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    always #5 clk = ~clk;

    hazard_control_unit #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
        .CLK            (clk),
        .Reset          (Reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRs      (ID_UsesRs),
        .ID_UsesRt      (ID_UsesRt),
        .ID_MulDiv      (ID_MulDiv),
        .ID_ReadsHiLo   (ID_ReadsHiLo),
        .EX_Rw          (EX_Rw),
        .EX_MemRead     (EX_MemRead),
        .EX_RegWrite    (EX_RegWrite),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFIDFlush      (IFIDFlush),
        .IDEXBubble     (IDEXBubble),
        .MdBusy         (MdBusy),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = sb.pop_front();
            act = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MdBusy};
            checks++;
            if (act !== e.o || StallCycles !== e.sc || FlushCount !== e.fc) begin
                errors++;
                $display("FAIL %s: ctl got %b exp %b, StallCycles got %0d exp %0d, FlushCount got %0d exp %0d",
                         e.nm, act, e.o, StallCycles, e.sc, FlushCount, e.fc);
            end
        end
    end

    task automatic set_in(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic md, input logic hl,
                          input logic [4:0] rw, input logic mr, input logic rwe, input logic br);
        Reset          = rst;
        ID_Rs          = rs;
        ID_Rt          = rt;
        ID_UsesRs      = urs;
        ID_UsesRt      = urt;
        ID_MulDiv      = md;
        ID_ReadsHiLo   = hl;
        EX_Rw          = rw;
        EX_MemRead     = mr;
        EX_RegWrite    = rwe;
        EX_BranchTaken = br;
    endtask

    task automatic idle();
        set_in(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic cyc(input string nm, input logic [4:0] o, input int sc, input int fc);
        exp_t e;
        e.nm = nm;
        e.o  = o;
        e.sc = CNT_W'(sc);
        e.fc = CNT_W'(fc);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc("reset_outputs", E_RST, 0, 0);
        idle();                                                  cyc("idle", E_NORM, 0, 0);

        // load-use on rs, then released
        set_in(0, 5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 1, 0);        cyc("lu_rs_stall", E_STALL, 0, 0);
        set_in(0, 5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0);        cyc("lu_rs_release", E_NORM, 1, 0);
        set_in(0, 5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 1, 1, 0);        cyc("lu_r0_nostall", E_NORM, 1, 0);
        set_in(0, 5'd5, 5'd5, 0, 1, 0, 0, 5'd5, 1, 1, 0);        cyc("lu_rt_stall", E_STALL, 1, 0);
        set_in(0, 5'd5, 5'd5, 0, 0, 0, 0, 5'd5, 1, 1, 0);        cyc("lu_unused_src", E_NORM, 2, 0);
        set_in(0, 5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 1, 0, 0);        cyc("lu_no_regwrite", E_NORM, 2, 0);

        // mult then mfhi
        set_in(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);        cyc("mult_issue", E_NORM, 2, 0);
        set_in(0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("mfhi_hold", E_STALL | BUSY, 2 + i, 0);
        cyc("mfhi_go", E_NORM, 6, 0);

        // branch beats load-use; branch blocks mult issue
        set_in(0, 5'd9, 5'd0, 1, 0, 0, 0, 5'd9, 1, 1, 1);        cyc("br_over_lu", E_FLUSH, 6, 0);
        idle();                                                  cyc("after_br", E_NORM, 6, 1);
        set_in(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1);        cyc("br_blocks_md", E_FLUSH, 6, 1);
        set_in(0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0);        cyc("no_md_issued", E_NORM, 6, 2);

        // mult then div back to back, branch during busy
        set_in(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);        cyc("mult_issue2", E_NORM, 6, 2);
        for (int i = 0; i < 4; i++) cyc("div_hold", E_STALL | BUSY, 6 + i, 2);
        cyc("div_issue", E_NORM, 10, 2);
        idle();                                                  cyc("div_busy1", E_NORM | BUSY, 10, 2);
        set_in(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1);        cyc("br_in_busy", E_FLUSH | BUSY, 10, 2);
        idle();                                                  cyc("div_busy3", E_NORM | BUSY, 10, 3);
        cyc("div_busy4", E_NORM | BUSY, 10, 3);
        cyc("div_done", E_NORM, 10, 3);

        // reset during MD_BUSY
        set_in(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);        cyc("mult_issue3", E_NORM, 10, 3);
        idle();                                                  cyc("busy_pre_rst", E_NORM | BUSY, 10, 3);
        set_in(1, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0);        cyc("rst_in_busy", E_RST, 10, 3);
        set_in(0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0);        cyc("post_rst_run", E_NORM, 0, 0);

        // stall counter saturation
        set_in(0, 5'd7, 5'd0, 1, 0, 0, 0, 5'd7, 1, 1, 0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            cyc("sat_stall", E_STALL, (i > 65535) ? 65535 : i, 0);
        idle();                                                  cyc("sat_hold", E_NORM, 65535, 0);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit in ID/EX.
- Detects hazards that forwarding cannot cover: load-use, and HI/LO or mult/div use while the multi-cycle multiplier/divider is busy.
- Resolves taken-branch squashes in EX.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue (legal range 1..255).
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  pipeline clock.
- Reset  in  1  synchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- ID_MulDiv  in  1  ID instruction is mult/multu/div/divu.
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- EX_Rw  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  EX instruction is a load.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IFIDFlush  out  1  IF/ID register loads a NOP.
- IDEXBubble  out  1  ID/EX register loads a NOP; control bits are zeroed.
- MdBusy  out  1  mult/div unit busy.
- StallCycles  out  CNT_W  count of hazard stall cycles.
- FlushCount  out  CNT_W  count of taken-branch flushes.

Behaviour:
- State register: {RUN, MD_BUSY}, plus an 8-bit down-counter md_cnt.
- Outputs are combinational from the state and the inputs. Counters are registered.
- Reset (at the edge where Reset is high):
  - state=RUN, md_cnt=0, StallCycles=0, FlushCount=0.
  - While Reset is high: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, MdBusy=0.
  - Reset mid-operation abandons MD_BUSY immediately.
- load_use = EX_MemRead & EX_RegWrite & (EX_Rw!=0) & ((ID_UsesRs & ID_Rs==EX_Rw) | (ID_UsesRt & ID_Rt==EX_Rw)).
- md_hazard = (state==MD_BUSY) & (ID_ReadsHiLo | ID_MulDiv).
- stall = load_use | md_hazard.
- Priority, highest first:
  - EX_BranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1. The stall is suppressed because the ID instruction is squashed. FlushCount increments (saturating).
  - stall: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1. StallCycles increments (saturating at all-ones).
  - otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- Load-use stall lasts exactly one cycle; on the next cycle the load is in MEM and forwarding covers it. No state is used.
- Mult/div issue occurs when state==RUN, ID_MulDiv=1, no stall and no EX_BranchTaken. Next edge: state=MD_BUSY, md_cnt=MD_LATENCY-1.
- In MD_BUSY:
  - md_cnt decrements each cycle.
  - When md_cnt==0, next state is RUN.
  - MdBusy=1 throughout, including the md_cnt==0 cycle.
  - A HI/LO reader is therefore held exactly MD_LATENCY cycles after the issue edge.
- EX_BranchTaken during MD_BUSY flushes normally. The countdown continues because the issued mult/div is older and not squashed.
- A mult/div that was stalled in MD_BUSY issues in the first RUN cycle, if no other hazard is present.
- Counter saturation: a counter at all-ones holds. There is no wrap-around.

Decomposition:
- Shared package (mips_pkg):
  - state encoding constants ST_RUN=1'b0, ST_MD_BUSY=1'b1.
  - REG_ZERO=5'd0.
  - default MD_LATENCY.
- One sub-module: sat_counter (CNT_W-bit saturating counter with synchronous clear and increment enable), instantiated twice.

Test Plan:
- Load-use: EX lw with Rw=8, MemRead=1, RegWrite=1; ID add with Rs=8, UsesRs=1 -> for one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1, StallCycles 0->1; next cycle normal. Repeat with EX_Rw=0 -> no stall.
- Mult/div busy, MD_LATENCY=4: mult issues in cycle 0, mfhi in ID from cycle 1 -> stall in cycles 1-4, MdBusy=1 in cycles 1-4, mfhi proceeds in cycle 5, StallCycles=4.
- Branch plus load-use in the same cycle -> IFIDFlush=1, IDEXBubble=1, PCWrite=1, FlushCount+1, StallCycles unchanged. Branch taken with ID_MulDiv=1 -> no issue, state stays RUN.
- Reset asserted at cycle 2 of MD_BUSY -> during Reset: PCWrite=0, IFIDFlush=1, IDEXBubble=1, MdBusy=0. After release: RUN, counters 0.
- Saturation: preload by forcing 2^CNT_W+3 load-use stall cycles -> StallCycles holds 0xFFFF.
- Back-to-back mult then div in ID, MD_LATENCY=4 -> div stalls 4 cycles, issues in cycle 5, MdBusy=1 again in cycles 6-9.
